tmem_crossbar_scheduler: RTL
============================

// Module: tmem_crossbar_scheduler
// PURPOSE
//  Schedules texture-memory (TMEM) reads from NUM_CORES cores onto NUM_BANKS interleaved single-read-port banks.
//  Per bank: one round-robin arbiter and a 2-stage read pipeline (issue, data), all registered.
//  Maps virtual to bank address and returns data with a one-cycle grant pulse per core.
//  Sits between the cores' TMEM_ADR_O/TMEM_CYC_O/TMEM_GNT_I/TMEM_DAT_I and the TMEM bank RAMs.
// PARAMETERS
//  NUM_CORES  4   requesting cores
//  NUM_BANKS  4   TMEM banks, power of two
//  BANK_BITS  2   log2(NUM_BANKS)
//  AW         32  address width
//  DW         32  data width
// PORTS
//  CLK_I       in   1             clock
//  RST_I       in   1             reset, synchronous, active-high
//  REQ_I       in   NUM_CORES     per-core read request (level)
//  ADR_I       in   NUM_CORES*AW  per-core virtual address, core i at [i*AW +: AW]
//  GNT_O       out  NUM_CORES     per-core one-cycle pulse: read complete, DAT_O valid
//  DAT_O       out  NUM_CORES*DW  per-core read data, held until that core's next GNT_O
//  BANK_RE_O   out  NUM_BANKS     per-bank read issue strobe
//  BANK_ADR_O  out  NUM_BANKS*AW  per-bank physical address
//  BANK_DAT_I  in   NUM_BANKS*DW  per-bank read data, valid 1 cycle after BANK_RE_O
// BEHAVIOUR
//  Reset: GNT_O, DAT_O, BANK_RE_O, BANK_ADR_O = 0; pipelines empty; busy flags clear; RR pointers = NUM_CORES-1, so core 0 wins first.
//  Address mapping:
//   - bank = ADR[BANK_BITS-1:0]
//   - phys = ADR >> BANK_BITS, zero-filled at the top
//  Eligibility: core i is eligible for bank b when REQ_I[i]=1, bank(ADR_I[i])=b and busy[i]=0.
//  busy[i] is set on issue and cleared after the GNT_O[i] cycle. At most one read is outstanding per core.
//  Arbitration (combinational per bank, every cycle):
//   - Winner is the first eligible core scanning upward from ptr[b]+1, mod NUM_CORES.
//   - At the clock edge: ptr[b] <= winner, busy[winner] <= 1.
//   - Stage-1 regs <= {valid, id, phys}. No eligible core: valid=0, ptr unchanged.
//  Pipeline per bank:
//   - cycle t: REQ sampled.
//   - t+1: BANK_RE_O[b]=1, BANK_ADR_O[b]=phys.
//   - t+2: BANK_DAT_I valid; stage-2 captures it with id.
//   - t+3: GNT_O[id]=1, DAT_O[id]=data.
//   - Uncontended latency REQ to GNT = 3 cycles.
//  Throughput: a bank may issue every cycle to different cores (full pipelining). One core gets at most one read per 4 cycles.
//  BANK_ADR_O holds its last value when BANK_RE_O=0.
//  Core handshake:
//   - REQ_I/ADR_I are sampled only at issue.
//   - REQ_I seen during the GNT_O cycle is ignored (still busy).
//   - A new request is considered from the cycle after GNT_O.
//  Cross-bank: different banks run independently. Several GNT_O bits may pulse in the same cycle, never two reads for one core.
//  Withdrawal: REQ_I dropped before issue means the core is simply not considered. Dropped after issue: the read completes and GNT_O still pulses.
//  Bank change: ADR_I changed after issue has no effect on the outstanding read.
//  Fairness: a continuously eligible core is issued within NUM_CORES-1 issues of its bank.
//  Reset mid-operation: in-flight reads are discarded, no GNT_O is generated, and state returns to reset values next cycle.
// TESTING
//  1 Core 0 REQ, ADR=0x13 @c0 -> c1 BANK_RE_O[3]=1, BANK_ADR_O[3]=0x4; c3 GNT_O=4'b0001, DAT_O[0]=bank3 word 0x4.
//  2 Cores 0-3 hold REQ, all ADR bank 1 (0x1,0x5,0x9,0xD) -> issues 0,1,2,3 on consecutive cycles; GNTs c3..c6 in order; phys 0,1,2,3.
//  3 Cores 0-3 on banks 0-3 (ADR 0x0,0x1,0x2,0x3) same cycle -> all four BANK_RE_O @c1; GNT_O=4'b1111 @c3.
//  4 Core 2 holds REQ to bank 0, core 1 re-requests at every opportunity (same bank) -> issues alternate 2,1,2,1; core 2 never waits >1 issue.
//  5 Core 0 issued then REQ dropped @c1 -> GNT_O[0] still @c3. Core 1 REQ withdrawn @c0 while core 0 wins -> core 1 never issued.
//  6 RST_I=1 @c2 during 2 in-flight reads -> no GNT_O; all outputs 0 @c3; next request is served by core 0 first.

Source files
------------

// File: rtl/tmem_crossbar_scheduler.sv
// ---------------------------------------------------------------------------
// tmem_crossbar_scheduler
//
// Purpose:
//   Schedules texture-memory reads from NUM_CORES cores onto NUM_BANKS
//   low-order-interleaved single-read-port banks. Each bank has its own
//   round-robin arbiter and a registered two-stage read pipeline
//   (issue, data). The read data is returned to the requesting core through
//   a per-core output register that carries a one-cycle grant pulse.
//
//   Timing for an uncontended read whose request is sampled at the end of
//   cycle t:
//     t+1  BANK_RE_O[b] = 1, BANK_ADR_O[b] = physical address
//     t+2  bank RAM drives BANK_DAT_I[b]
//     t+3  GNT_O[core] = 1, DAT_O[core] = read data
//   The core is busy from issue until the end of its grant cycle, so its next
//   request can be sampled at the end of t+4.
//
// Ports:
//   CLK_I       in   clock
//   RST_I       in   synchronous active-high reset
//   REQ_I       in   [NUM_CORES]     per-core read request (level)
//   ADR_I       in   [NUM_CORES*AW]  per-core virtual address, core i at [i*AW +: AW]
//   GNT_O       out  [NUM_CORES]     per-core one-cycle read-complete pulse
//   DAT_O       out  [NUM_CORES*DW]  per-core read data, held until next grant
//   BANK_RE_O   out  [NUM_BANKS]     per-bank read strobe
//   BANK_ADR_O  out  [NUM_BANKS*AW]  per-bank physical address, held when idle
//   BANK_DAT_I  in   [NUM_BANKS*DW]  per-bank read data, one cycle after BANK_RE_O
// ---------------------------------------------------------------------------
module tmem_crossbar_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int NUM_BANKS = 4,
    parameter int BANK_BITS = 2,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic                      CLK_I,
    input  logic                      RST_I,
    input  logic [NUM_CORES-1:0]      REQ_I,
    input  logic [NUM_CORES*AW-1:0]   ADR_I,
    output logic [NUM_CORES-1:0]      GNT_O,
    output logic [NUM_CORES*DW-1:0]   DAT_O,
    output logic [NUM_BANKS-1:0]      BANK_RE_O,
    output logic [NUM_BANKS*AW-1:0]   BANK_ADR_O,
    input  logic [NUM_BANKS*DW-1:0]   BANK_DAT_I
);

    localparam int IDW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    // Pointer starts at the last core so that core 0 is first in line.
    localparam logic [IDW-1:0] PTR_RST = IDW'(NUM_CORES - 1);

    // Control state
    logic [NUM_CORES-1:0]            busy_q, busy_d;
    logic [NUM_BANKS-1:0][IDW-1:0]   ptr_q,  ptr_d;

    // Issue stage
    logic [NUM_BANKS-1:0]            vld_p1_q, vld_p1_d;
    logic [NUM_BANKS-1:0][IDW-1:0]   id_p1_q,  id_p1_d;
    logic [NUM_BANKS-1:0][AW-1:0]    adr_p1_q, adr_p1_d;

    // Data stage
    logic [NUM_BANKS-1:0]            vld_p2_q, vld_p2_d;
    logic [NUM_BANKS-1:0][IDW-1:0]   id_p2_q,  id_p2_d;

    // Per-core return registers
    logic [NUM_CORES-1:0]            gnt_p3_q, gnt_p3_d;
    logic [NUM_CORES-1:0][DW-1:0]    dat_p3_q, dat_p3_d;

    // Combinational arbitration terms
    logic [NUM_CORES-1:0][AW-1:0]        phys;
    logic [NUM_BANKS-1:0][NUM_CORES-1:0] elig;
    logic [NUM_BANKS-1:0]                win_vld;
    logic [NUM_BANKS-1:0][IDW-1:0]       win_id;

    // Address decode and eligibility. A core targets exactly one bank, so a
    // core can never be picked by two arbiters in the same cycle.
    always_comb begin
        phys = '0;
        elig = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            phys[i] = ADR_I[i*AW +: AW] >> BANK_BITS;
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                elig[b][i] = REQ_I[i] && !busy_q[i] &&
                             (ADR_I[i*AW +: BANK_BITS] == BANK_BITS'(b));
            end
        end
    end

    // Round-robin pick per bank: first eligible core scanning upward from
    // ptr+1, wrapping at NUM_CORES. The pointer itself is the lowest priority.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = '0;
        win_id  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int k = 1; k <= NUM_CORES; k++) begin
                idx = int'(ptr_q[b]) + k;
                if (idx >= NUM_CORES) begin
                    idx = idx - NUM_CORES;
                end
                if (!win_vld[b] && elig[b][idx]) begin
                    win_vld[b] = 1'b1;
                    win_id[b]  = IDW'(idx);
                end
            end
        end
    end

    always_comb begin
        // Busy clears at the end of the grant cycle; a request seen during
        // that cycle is still masked by busy_q.
        busy_d   = busy_q & ~gnt_p3_q;
        ptr_d    = ptr_q;

        // Arbitration -> issue stage
        vld_p1_d = win_vld;
        id_p1_d  = win_id;
        adr_p1_d = adr_p1_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (win_vld[b]) begin
                ptr_d[b]          = win_id[b];
                busy_d[win_id[b]] = 1'b1;
                adr_p1_d[b]       = phys[win_id[b]];
            end
        end

        // Issue stage -> data stage: the bank is reading, track whose read it is
        vld_p2_d = vld_p1_q;
        id_p2_d  = id_p1_q;

        // Data stage -> per-core return registers
        gnt_p3_d = '0;
        dat_p3_d = dat_p3_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (vld_p2_q[b]) begin
                gnt_p3_d[id_p2_q[b]] = 1'b1;
                dat_p3_d[id_p2_q[b]] = BANK_DAT_I[b*DW +: DW];
            end
        end
    end

    // Every register is cleared by reset so in-flight reads are dropped and
    // all outputs read zero in the cycle after reset.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            busy_q   <= '0;
            ptr_q    <= {NUM_BANKS{PTR_RST}};
            vld_p1_q <= '0;
            id_p1_q  <= '0;
            adr_p1_q <= '0;
            vld_p2_q <= '0;
            id_p2_q  <= '0;
            gnt_p3_q <= '0;
            dat_p3_q <= '0;
        end else begin
            busy_q   <= busy_d;
            ptr_q    <= ptr_d;
            vld_p1_q <= vld_p1_d;
            id_p1_q  <= id_p1_d;
            adr_p1_q <= adr_p1_d;
            vld_p2_q <= vld_p2_d;
            id_p2_q  <= id_p2_d;
            gnt_p3_q <= gnt_p3_d;
            dat_p3_q <= dat_p3_d;
        end
    end

    assign BANK_RE_O  = vld_p1_q;
    assign BANK_ADR_O = adr_p1_q;
    assign GNT_O      = gnt_p3_q;
    assign DAT_O      = dat_p3_q;

endmodule
